// File: rtl/param_shift_engine.sv
// Multi-cycle shift/rotate register: one bit position per clock, with load,
// serial fill/drain and a start/busy/done handshake.
module param_shift_engine #(
  parameter int WIDTH     = 8,
  parameter int MAX_SHIFT = WIDTH,
  parameter int AMT_W     = $clog2(MAX_SHIFT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] Data_IN,
  input  logic             serial_in,
  input  logic             pause,
  output logic [WIDTH-1:0] Q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_ROR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_LSR  = 3'b100;
  localparam logic [2:0] MODE_LSL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next, step_q;
  logic             so_reg, so_next, step_bit;
  logic             done_reg, done_next;
  logic [AMT_W-1:0] cnt_reg, cnt_next, amt_clamped;
  logic [2:0]       mode_reg, mode_next;
  logic             is_shift_mode;

  assign amt_clamped   = (amount > AMT_W'(MAX_SHIFT)) ? AMT_W'(MAX_SHIFT) : amount;
  assign is_shift_mode = (mode >= MODE_ROR) && (mode <= MODE_ASR);

  // Single-bit step using the mode latched at accept, not the live input.
  always_comb begin
    step_q   = q_reg;
    step_bit = so_reg;
    case (mode_reg)
      MODE_ROR: begin
        step_q   = {q_reg[0], q_reg[WIDTH-1:1]};
        step_bit = q_reg[0];
      end
      MODE_ROL: begin
        step_q   = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        step_bit = q_reg[WIDTH-1];
      end
      MODE_LSR: begin
        step_q   = {serial_in, q_reg[WIDTH-1:1]};
        step_bit = q_reg[0];
      end
      MODE_LSL: begin
        step_q   = {q_reg[WIDTH-2:0], serial_in};
        step_bit = q_reg[WIDTH-1];
      end
      MODE_ASR: begin
        step_q   = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
        step_bit = q_reg[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    so_next    = so_reg;
    done_next  = 1'b0;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (mode == MODE_LOAD) begin
            q_next    = Data_IN;
            done_next = 1'b1;
          end else if (is_shift_mode && (amount != '0)) begin
            cnt_next   = amt_clamped;
            mode_next  = mode;
            state_next = SHIFT;
          end else begin
            // hold, reserved and zero-length requests complete immediately
            done_next = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (!pause) begin
          q_next   = step_q;
          so_next  = step_bit;
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == AMT_W'(1)) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      so_reg    <= 1'b0;
      done_reg  <= 1'b0;
      cnt_reg   <= '0;
      mode_reg  <= MODE_HOLD;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      so_reg    <= so_next;
      done_reg  <= done_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
    end
  end

  assign Q          = q_reg;
  assign serial_out = so_reg;
  assign busy       = (state_reg == SHIFT);
  assign done       = done_reg;

endmodule

// File: tb/tb_param_shift_engine.sv
// Randomized and directed checks of param_shift_engine (WIDTH=8) against a
// closed-form arithmetic model of each N-step operation.
module tb_param_shift_engine;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] mode;
  logic [3:0] amount;
  logic [7:0] Data_IN;
  logic       serial_in;
  logic       pause;
  logic [7:0] Q;
  logic       serial_out;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  int last_busy = 0;
  logic [7:0] q_model = 8'h00;
  logic       so_model = 1'b0;

  param_shift_engine #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .amount(amount),
    .Data_IN(Data_IN), .serial_in(serial_in), .pause(pause),
    .Q(Q), .serial_out(serial_out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result of n single-bit steps, computed in one go: returns {serial_out, Q}.
  function automatic logic [8:0] model_op(input logic [7:0] q, input logic [2:0] m,
                                          input int n, input logic sin);
    int v, top, low, r, so;
    v   = int'(q);
    top = ((1 << n) - 1) << (8 - n);
    low = (1 << n) - 1;
    r   = v;
    so  = 0;
    case (m)
      3'd2: begin r = ((v >> n) | (v << (8 - n))) & 255; so = (v >> (n - 1)) & 1; end
      3'd3: begin r = ((v << n) | (v >> (8 - n))) & 255; so = (v >> (8 - n)) & 1; end
      3'd4: begin r = (v >> n) | (sin ? top : 0);         so = (v >> (n - 1)) & 1; end
      3'd5: begin r = ((v << n) & 255) | (sin ? low : 0); so = (v >> (8 - n)) & 1; end
      3'd6: begin r = (v >> n) | (q[7] ? top : 0);        so = (v >> (n - 1)) & 1; end
      default: ;
    endcase
    return {so[0], r[7:0]};
  endfunction

  // Issues one request at the current negedge and follows it to its done cycle.
  // pmode: 0 no pause, 1 random pause + ignored start pulses, 2 pause on busy cycles 2 and 3.
  task automatic run_op(input logic [2:0] m, input logic [3:0] amt, input logic [7:0] d,
                        input logic sin, input int pmode);
    int n, bc, pc, guard;
    bit is_shift;
    logic [8:0] res;
    start = 1'b1; mode = m; amount = amt; Data_IN = d; serial_in = sin; pause = 1'b0;
    @(negedge clock);
    start = 1'b0;
    n = (amt > 4'd8) ? 8 : int'(amt);
    is_shift = (m >= 3'd2) && (m <= 3'd6) && (n > 0);
    if (!is_shift) begin
      if (m == 3'd1) q_model = d;
      check("idle_done", done, 1);
      check("idle_busy", busy, 0);
      check("idle_q", Q, q_model);
      check("idle_so", serial_out, so_model);
      last_busy = 0;
      $display("[TB] op mode=%0d amt=%0d -> Q=%02h done=%0b", m, amt, Q, done);
    end else begin
      res = model_op(q_model, m, n, sin);
      bc = 0; pc = 0; guard = 0;
      check("accept_busy", busy, 1);
      while (busy === 1'b1 && guard < 100) begin
        check("busy_no_done", done, 0);
        bc++;
        case (pmode)
          1:       pause = ($urandom % 4) == 0;
          2:       pause = (bc == 2) || (bc == 3);
          default: pause = 1'b0;
        endcase
        if (pause) pc++;
        if (pmode != 0) begin
          start = $urandom % 2; mode = 3'b001; Data_IN = 8'($urandom);
        end
        @(negedge clock);
        guard++;
      end
      start = 1'b0; pause = 1'b0;
      check("op_timeout", guard < 100, 1);
      check("busy_len", bc, n + pc);
      check("shift_done", done, 1);
      check("shift_q", Q, res[7:0]);
      check("shift_so", serial_out, res[8]);
      q_model = res[7:0];
      so_model = res[8];
      last_busy = bc;
      $display("[TB] op mode=%0d amt=%0d sin=%0b -> Q=%02h so=%0b busy=%0d (pauses %0d)",
               m, amt, sin, Q, serial_out, bc, pc);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 3'd0; amount = 4'd0;
    Data_IN = 8'h00; serial_in = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_q", Q, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_so", serial_out, 0);
    reset = 1'b0;

    // 1: load
    run_op(3'd1, 4'd0, 8'hA5, 1'b0, 0);
    check("t1_q", Q, 8'hA5);
    // 2: ROR 3
    run_op(3'd2, 4'd3, 8'h00, 1'b0, 0);
    check("t2_q", Q, 8'hB4);
    check("t2_so", serial_out, 1);
    check("t2_busy", last_busy, 3);
    // 3: ASR and LSL with fill
    run_op(3'd1, 4'd0, 8'h96, 1'b0, 0);
    run_op(3'd6, 4'd2, 8'h00, 1'b0, 0);
    check("t3_asr", Q, 8'hE5);
    run_op(3'd1, 4'd0, 8'h81, 1'b0, 0);
    run_op(3'd5, 4'd3, 8'h00, 1'b1, 0);
    check("t3_lsl", Q, 8'h0F);
    check("t3_so", serial_out, 0);
    // 4: ROR 4 with a two-cycle pause and ignored start pulses
    run_op(3'd1, 4'd0, 8'hA5, 1'b0, 0);
    run_op(3'd2, 4'd4, 8'h00, 1'b0, 2);
    check("t4_q", Q, 8'h5A);
    check("t4_busy", last_busy, 6);
    // 5: reset aborts a ROL 5
    run_op(3'd1, 4'd0, 8'hA5, 1'b0, 0);
    start = 1'b1; mode = 3'd3; amount = 4'd5;
    @(negedge clock);
    start = 1'b0;
    check("t5_busy", busy, 1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t5_q", Q, 8'h00);
    check("t5_busy0", busy, 0);
    check("t5_done0", done, 0);
    check("t5_so", serial_out, 0);
    reset = 1'b0;
    q_model = 8'h00; so_model = 1'b0;
    @(negedge clock);
    check("t5_nodone", done, 0);
    $display("[TB] reset abort -> Q=%02h busy=%0b done=%0b", Q, busy, done);
    run_op(3'd1, 4'd0, 8'hA5, 1'b0, 0);
    run_op(3'd3, 4'd0, 8'h00, 1'b0, 0);
    check("t5_rol0", Q, 8'hA5);
    // 6: clamp, then back-to-back start on the done cycle
    run_op(3'd3, 4'd12, 8'h00, 1'b0, 0);
    check("t6_q", Q, 8'hA5);
    check("t6_busy", last_busy, 8);
    run_op(3'd2, 4'd1, 8'h00, 1'b0, 0);
    check("t6_b2b", Q, 8'hD2);

    // randomized requests, back-to-back or separated by idle gaps
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 8'($urandom),
             1'($urandom), int'($urandom_range(0, 1)));
      if ($urandom % 3 == 0) begin
        @(negedge clock);
        check("gap_done", done, 0);
        check("gap_busy", busy, 0);
        check("gap_q", Q, q_model);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
